// File: rtl/ldm_stm_seq_if.sv
// Bus bundle for the LDM/STM sequencer: request fields, register-file and
// data-memory ports, plus status. master = requester/environment, slave = sequencer.
interface ldm_stm_seq_if;
  logic        start;
  logic [15:0] reglist;
  logic [31:0] base;
  logic [3:0]  rn;
  logic        l_bit;
  logic        u_bit;
  logic        p_bit;
  logic        w_bit;
  logic [31:0] rf_rd;
  logic [31:0] mem_rdata;
  logic [3:0]  rf_ra;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  modport master (
    output start, reglist, base, rn, l_bit, u_bit, p_bit, w_bit, rf_rd, mem_rdata,
    input  rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd, mem_addr, mem_we, mem_wdata, busy, done
  );

  modport slave (
    input  start, reglist, base, rn, l_bit, u_bit, p_bit, w_bit, rf_rd, mem_rdata,
    output rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd, mem_addr, mem_we, mem_wdata, busy, done
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// ARM-style block transfer sequencer: walks a 16-bit register list one register
// per cycle, then optionally writes the updated base back to Rn.
module ldm_stm_seq (
  input  logic           clk,
  input  logic           reset,
  ldm_stm_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [3:0]  rn_q, rn_d;
  logic        load_q, load_d;
  logic        wb_q, wb_d;
  logic        wb_en_q, wb_en_d;

  logic [4:0]  cnt_s;
  logic [31:0] offs_s;
  logic [3:0]  idx_s;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = i[3:0];
      else      r = r;
    end
    return r;
  endfunction

  assign cnt_s  = popcount16(bus.reglist);
  assign offs_s = {25'd0, cnt_s, 2'b00};
  assign idx_s  = lowest_idx(list_q);

  // Next-state: latch the request in IDLE, retire one list bit per XFER cycle.
  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    addr_d   = addr_q;
    wb_val_d = wb_val_q;
    rn_d     = rn_q;
    load_d   = load_q;
    wb_d     = wb_q;
    wb_en_d  = wb_en_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          list_d   = bus.reglist;
          rn_d     = bus.rn;
          load_d   = bus.l_bit;
          wb_d     = bus.w_bit;
          wb_en_d  = !(bus.l_bit && bus.reglist[bus.rn]);
          wb_val_d = bus.u_bit ? (bus.base + offs_s) : (bus.base - offs_s);
          case ({bus.u_bit, bus.p_bit})
            2'b10:   addr_d = bus.base;
            2'b11:   addr_d = bus.base + 32'd4;
            2'b00:   addr_d = bus.base - offs_s + 32'd4;
            2'b01:   addr_d = bus.base - offs_s;
            default: addr_d = bus.base;
          endcase
          if (bus.reglist != 16'd0) state_d = XFER;
          else if (bus.w_bit)       state_d = WB;
          else                      state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        addr_d = addr_q + 32'd4;
        list_d = list_q & (list_q - 16'd1);
        if (list_d != 16'd0) state_d = XFER;
        else if (wb_q)       state_d = WB;
        else                 state_d = DONE;
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      list_q   <= 16'd0;
      addr_q   <= 32'd0;
      wb_val_q <= 32'd0;
      rn_q     <= 4'd0;
      load_q   <= 1'b0;
      wb_q     <= 1'b0;
      wb_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      addr_q   <= addr_d;
      wb_val_q <= wb_val_d;
      rn_q     <= rn_d;
      load_q   <= load_d;
      wb_q     <= wb_d;
      wb_en_q  <= wb_en_d;
    end
  end

  // Output decode from registered state; read data passes straight through.
  always_comb begin
    bus.rf_ra     = 4'd0;
    bus.rf_we     = 1'b0;
    bus.rf_wa     = 4'd0;
    bus.rf_wd     = 32'd0;
    bus.pc_we     = 1'b0;
    bus.pc_wd     = 32'd0;
    bus.mem_addr  = 32'd0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'd0;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    case (state_q)
      XFER: begin
        bus.mem_addr = addr_q;
        if (load_q) begin
          if (idx_s == 4'd15) begin
            bus.pc_we = 1'b1;
            bus.pc_wd = bus.mem_rdata;
          end else begin
            bus.rf_we = 1'b1;
            bus.rf_wa = idx_s;
            bus.rf_wd = bus.mem_rdata;
          end
        end else begin
          bus.rf_ra     = idx_s;
          bus.mem_we    = 1'b1;
          bus.mem_wdata = bus.rf_rd;
        end
      end
      WB: begin
        // A loaded Rn takes priority over the updated base.
        if (wb_en_q) begin
          bus.rf_we = 1'b1;
          bus.rf_wa = rn_q;
          bus.rf_wd = wb_val_q;
        end else begin
          bus.rf_we = 1'b0;
        end
      end
      default: bus.rf_we = 1'b0;
    endcase
  end

endmodule
